// File: rtl/module_bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package module_bcd_pkg;

  // Converter control states: waiting, shifting one bit per clock, result pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest legal decimal digit.
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  // A digit at or above this value after a right shift picked up a stray 8
  // that should have been a 5 (half of the digit's weight of 10).
  localparam logic [3:0] DABBLE_THRESH = 4'd8;
  localparam logic [3:0] DABBLE_CORR   = 4'd3;

  // True when a nibble is not a valid decimal digit.
  function automatic logic digit_invalid(input logic [3:0] digit);
    return digit > BCD_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/module_bcd_digit_corr.sv
// One-digit correction step of reverse double-dabble: subtract 3 when the
// shifted digit is 8 or more. Purely combinational, no carry between digits.
module module_bcd_digit_corr
  import module_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  // Apply the -3 adjustment when the digit reaches the threshold.
  always_comb begin
    corrected = digit;
    if (digit >= DABBLE_THRESH) begin
      corrected = digit - DABBLE_CORR;
    end
  end

endmodule

// File: rtl/module_bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble: the packed
// BCD operand is shifted right into a binary register one bit per clock and
// each BCD digit is corrected after every shift.
//
// Handshake: i_start is a request that is accepted only on an edge where
// o_busy is low (state IDLE); i_bcd is sampled on that same edge. Requests
// while busy are dropped, not queued. o_done is a one-cycle valid pulse; the
// result (o_bin, o_err, o_ovf) is valid from o_done and held until the next
// accepted start.
module module_bcd_to_bin_seq
  import module_bcd_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [4*N_DIGITS-1:0] i_bcd,
  output logic [BIN_W-1:0]      o_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_ovf,
  output state_t                dbg_state
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   bin_q;
  logic [BIN_W-1:0]   bin_out_q;
  logic               err_q;
  logic               ovf_q;

  logic [BCD_W-1:0]   bcd_shift;
  logic [BIN_W-1:0]   bin_shift;
  logic [BCD_W-1:0]   bcd_corr;
  logic               any_invalid;
  logic               accept;
  logic               last_shift;

  // Right shift of {bcd_q, bin_q}: the BCD LSB drops into the binary MSB.
  always_comb begin
    bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
    bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};
  end

  // Per-digit correction of the shifted BCD register.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_corr
    module_bcd_digit_corr u_corr (
      .digit     (bcd_shift[4*g +: 4]),
      .corrected (bcd_corr[4*g +: 4])
    );
  end

  // Flag any nibble of the incoming operand that is not a decimal digit.
  always_comb begin
    any_invalid = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      any_invalid = any_invalid | digit_invalid(i_bcd[4*i +: 4]);
    end
  end

  assign accept     = (state_q == IDLE) && i_start;
  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_LAST);

  // Next-state logic: invalid operands skip straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = any_invalid ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: load on accept, shift-and-correct in SHIFT, publish on last shift.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q     <= '0;
      bcd_q     <= '0;
      bin_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      bcd_q <= i_bcd;
      bin_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= any_invalid;
      if (any_invalid) begin
        bin_out_q <= '0;
      end
    end else if (state_q == SHIFT) begin
      bcd_q <= bcd_corr;
      bin_q <= bin_shift;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_shift) begin
        bin_out_q <= bin_shift;
        // Anything left in the BCD register did not fit in BIN_W bits.
        ovf_q     <= |bcd_corr;
      end
    end
  end

  assign o_bin     = bin_out_q;
  assign o_err     = err_q;
  assign o_ovf     = ovf_q;
  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_module_bcd_to_bin_seq.sv
// Bench for the sequential BCD-to-binary converter: a 14-bit and a 12-bit
// instance, a decimal-arithmetic reference model, and a scoreboard per
// instance that checks every o_done against the queued expectation.
module tb_module_bcd_to_bin_seq;
  import module_bcd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic        start14, start12;
  logic [15:0] bcd14, bcd12;
  logic [13:0] bin14;
  logic [11:0] bin12;
  logic        busy14, done14, err14, ovf14;
  logic        busy12, done12, err12, ovf12;
  state_t      dbg14, dbg12;

  module_bcd_to_bin_seq #(.N_DIGITS(4), .BIN_W(14)) u_dut14 (
    .i_clk(clk), .i_rst(rst), .i_start(start14), .i_bcd(bcd14),
    .o_bin(bin14), .o_busy(busy14), .o_done(done14), .o_err(err14),
    .o_ovf(ovf14), .dbg_state(dbg14)
  );

  module_bcd_to_bin_seq #(.N_DIGITS(4), .BIN_W(12)) u_dut12 (
    .i_clk(clk), .i_rst(rst), .i_start(start12), .i_bcd(bcd12),
    .o_bin(bin12), .o_busy(busy12), .o_done(done12), .o_err(err12),
    .o_ovf(ovf12), .dbg_state(dbg12)
  );

  // ---------------- scoreboard state ----------------
  // Entry layout: {err, ovf, bin[13:0]}.
  logic [15:0] exp14_q[$];
  logic [15:0] exp12_q[$];
  int          acc14_q[$];
  int          acc12_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: read the four digits as a decimal number, then reduce.
  function automatic logic [15:0] model(input logic [15:0] bcd, input int w);
    int         val;
    logic [3:0] d;
    bit         bad;
    logic       ovf;
    int         lim;
    val = 0;
    bad = 0;
    for (int i = 3; i >= 0; i--) begin
      d   = bcd[4*i +: 4];
      if (d > 4'd9) bad = 1;
      val = val * 10 + int'(d);
    end
    if (bad) return {1'b1, 1'b0, 14'd0};
    lim = 1 << w;
    ovf = (val >= lim);
    return {1'b0, ovf, 14'(val % lim)};
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wait_idle(input bit sel12);
    int n = 0;
    while ((sel12 ? busy12 : busy14) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sel12 ? busy12 : busy14) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle%s: busy stuck high after %0d cycles", sel12 ? "12" : "14", n);
    end
  endtask

  // Drive one start request for one cycle; push an expectation if it will be accepted.
  task automatic issue(input bit sel12, input logic [15:0] bcd, input bit push);
    if (sel12) begin
      bcd12 = bcd; start12 = 1'b1;
      if (push) begin exp12_q.push_back(model(bcd, 12)); acc12_q.push_back(cyc + 1); end
    end else begin
      bcd14 = bcd; start14 = 1'b1;
      if (push) begin exp14_q.push_back(model(bcd, 14)); acc14_q.push_back(cyc + 1); end
    end
    @(negedge clk);
    start12 = 1'b0;
    start14 = 1'b0;
    bcd12   = $urandom;
    bcd14   = $urandom;
  endtask

  task automatic convert(input bit sel12, input logic [15:0] bcd);
    wait_idle(sel12);
    issue(sel12, bcd, 1'b1);
  endtask

  function automatic logic [15:0] rand_operand();
    logic [15:0] v;
    if ($urandom_range(0, 4) == 0) return 16'($urandom);
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // ---------------- monitors ----------------
  logic [15:0] last14, last12;
  bit          hold14 = 0, hold12 = 0;

  // 14-bit monitor: compare each done pulse, then check values hold and done drops.
  always @(negedge clk) begin
    logic [15:0] e;
    int          a;
    if (rst) begin
      hold14 = 0;
    end else begin
      if (hold14) begin
        chk("hold_bin14", bin14, last14[13:0]);
        chk("hold_flags14", {err14, ovf14}, last14[15:14]);
        chk("done_pulse14", done14, 1'b0);
        chk("idle_busy14", busy14, 1'b0);
        hold14 = 0;
      end
      if (done14) begin
        if (exp14_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_done14: got o_done=1 expected no result pending (t=%0t)", $time);
        end else begin
          e = exp14_q.pop_front();
          a = acc14_q.pop_front();
          chk("bin14", bin14, e[13:0]);
          chk("err14", err14, e[15]);
          chk("ovf14", ovf14, e[14]);
          chk("latency14", cyc - a, e[15] ? 0 : 14);
          last14 = e;
          hold14 = 1;
        end
      end
    end
  end

  // 12-bit monitor, same checks.
  always @(negedge clk) begin
    logic [15:0] e;
    int          a;
    if (rst) begin
      hold12 = 0;
    end else begin
      if (hold12) begin
        chk("hold_bin12", bin12, last12[11:0]);
        chk("hold_flags12", {err12, ovf12}, last12[15:14]);
        chk("done_pulse12", done12, 1'b0);
        hold12 = 0;
      end
      if (done12) begin
        if (exp12_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_done12: got o_done=1 expected no result pending (t=%0t)", $time);
        end else begin
          e = exp12_q.pop_front();
          a = acc12_q.pop_front();
          chk("bin12", bin12, e[11:0]);
          chk("err12", err12, e[15]);
          chk("ovf12", ovf12, e[14]);
          chk("latency12", cyc - a, e[15] ? 0 : 12);
          last12 = e;
          hold12 = 1;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    start14 = 1'b0; start12 = 1'b0;
    bcd14 = '0; bcd12 = '0;
    repeat (3) @(negedge clk);
    chk("rst_bin14", bin14, 0);
    chk("rst_flags14", {busy14, done14, err14, ovf14}, 0);
    chk("rst_state14", dbg14, IDLE);
    chk("rst_flags12", {bin12, busy12, done12, err12, ovf12}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed values, including the invalid-digit path.
    convert(0, 16'h1234);
    convert(0, 16'h9999);
    convert(0, 16'h0000);
    convert(0, 16'h12A4);
    convert(0, 16'hF000);

    // Starts during SHIFT and DONE are dropped; the next IDLE cycle accepts.
    wait_idle(0);
    issue(0, 16'h1234, 1'b1);
    repeat (4) @(negedge clk);
    chk("busy_in_shift", busy14, 1'b1);
    issue(0, 16'h5678, 1'b0);
    repeat (9) @(negedge clk);
    chk("state_done", dbg14, DONE);
    issue(0, 16'h5678, 1'b0);
    chk("idle_after_done", busy14, 1'b0);
    issue(0, 16'h5678, 1'b1);

    // Asynchronous reset in the middle of SHIFT.
    wait_idle(0);
    issue(0, 16'h1234, 1'b0);
    repeat (6) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_bin", bin14, 0);
    chk("midrst_flags", {busy14, done14, err14, ovf14}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    convert(0, 16'h1234);

    // Randomized traffic with random gaps, including back-to-back starts.
    for (int k = 0; k < 40; k++) begin
      wait_idle(0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(0, rand_operand(), 1'b1);
    end

    // Narrow instance: overflow and the largest value that fits.
    convert(1, 16'h9999);
    convert(1, 16'h4095);
    convert(1, 16'h4096);
    for (int k = 0; k < 12; k++) begin
      wait_idle(1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1, rand_operand(), 1'b1);
    end

    // Drain outstanding expectations.
    for (int n = 0; n < 100 && (exp14_q.size() != 0 || exp12_q.size() != 0); n++) begin
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("drain14", exp14_q.size(), 0);
    chk("drain12", exp12_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
